// File: rtl/column_scanner.sv
// column_scanner: time-multiplexed LED column driver.
// Scans N_COLS columns one at a time. Each column waits for a column_ready
// handshake, is lit for DISP_CYCLES, then blanked for GAP_CYCLES.
// frame_sync restarts the scan at column 0 after SYNC_DELAY cycles.
// Optional feature: define COLUMN_SCANNER_WATCHDOG_EN to add an on-time
// watchdog that cuts any column lit for MAX_ON_CYCLES consecutive cycles.
module column_scanner #(
    parameter int N_COLS        = 8,
    parameter int DISP_CYCLES   = 330,
    parameter int GAP_CYCLES    = 33,
    parameter int SYNC_DELAY    = 330,
    parameter int MAX_ON_CYCLES = 330
) (
    input  logic                      clk_33,
    input  logic                      nrst,
    input  logic                      enable,
    input  logic                      frame_sync,
    input  logic                      column_ready,
    input  logic                      clear_err,
    output logic [N_COLS-1:0]         mux_out,
    output logic [$clog2(N_COLS)-1:0] column_idx,
    output logic                      column_done,
    output logic                      overrun_err,
    output logic                      overdrive_err
);
    localparam int IW    = $clog2(N_COLS);
    localparam int MAXV0 = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
    localparam int MAXV  = (MAXV0 > SYNC_DELAY) ? MAXV0 : SYNC_DELAY;
    localparam int CW    = $clog2(MAXV + 1);

    localparam logic [CW-1:0] DISP_LAST = CW'(DISP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SYNC_LAST = CW'((SYNC_DELAY > 0) ? SYNC_DELAY - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_COLS - 1);

    if (N_COLS < 2 || N_COLS > 32 || DISP_CYCLES < 1 || GAP_CYCLES < 0 ||
        SYNC_DELAY < 0 || MAX_ON_CYCLES < 1) begin : g_bad_cfg
        $error("column_scanner: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, SYNC_WAIT, WAIT_READY, DISP, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx_nxt, idx_inc;
    logic          pend, pend_nxt;
    logic          wd_hit, disp_end, ovr_set;

    assign idx_inc  = (column_idx == IDX_LAST) ? '0 : column_idx + IW'(1);
    assign disp_end = (state == DISP) && ((cnt == DISP_LAST) || wd_hit);
    assign column_done = disp_end;

    // A second ready while one is still pending is an overrun; the pending
    // flag simply stays set.
    assign ovr_set = enable && !frame_sync && (state != IDLE) && column_ready && pend;

    // Column enable decoded purely from registered state, so it drops
    // immediately when the state register is reset.
    always_comb begin
        mux_out = '0;
        if (state == DISP) mux_out[column_idx] = 1'b1;
    end

`ifdef COLUMN_SCANNER_WATCHDOG_EN
    localparam int WW = $clog2(MAX_ON_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(MAX_ON_CYCLES - 1);
    logic [WW-1:0] wd_cnt;
    logic          odr_set;

    // Count consecutive cycles with any column lit, independent of the FSM counter.
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst)         wd_cnt <= '0;
        else if (|mux_out) wd_cnt <= wd_cnt + WW'(1);
        else               wd_cnt <= '0;
    end

    assign wd_hit  = (state == DISP) && (wd_cnt == WD_LAST);
    // Only a real cut counts: a natural end on the same cycle is not an error.
    assign odr_set = enable && !frame_sync && wd_hit && (cnt != DISP_LAST);

    // Sticky overdrive flag; a new cut wins over clear_err.
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst)          overdrive_err <= 1'b0;
        else if (odr_set)   overdrive_err <= 1'b1;
        else if (clear_err) overdrive_err <= 1'b0;
    end
`else
    assign wd_hit        = 1'b0;
    assign overdrive_err = 1'b0;
`endif

    // Next-state, counter, column index and ready-pending logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = column_idx;
        pend_nxt  = pend;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pend_nxt  = 1'b0;
        end else if (frame_sync) begin
            state_nxt = (SYNC_DELAY == 0) ? WAIT_READY : SYNC_WAIT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            pend_nxt  = 1'b0;
        end else begin
            if (state != IDLE && column_ready) pend_nxt = 1'b1;
            case (state)
                IDLE: ;
                SYNC_WAIT: begin
                    if (cnt == SYNC_LAST) begin
                        state_nxt = WAIT_READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                WAIT_READY: begin
                    if (pend || column_ready) begin
                        state_nxt = DISP;
                        cnt_nxt   = '0;
                        // consume one ready; a fresh pulse on top of a pending one stays queued
                        pend_nxt  = pend && column_ready;
                    end
                end
                DISP: begin
                    if (disp_end) begin
                        cnt_nxt = '0;
                        if (GAP_CYCLES == 0) begin
                            state_nxt = WAIT_READY;
                            idx_nxt   = idx_inc;
                        end else begin
                            state_nxt = GAP;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = WAIT_READY;
                        cnt_nxt   = '0;
                        idx_nxt   = idx_inc;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counter, index and pending registers.
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            column_idx <= '0;
            pend       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            column_idx <= idx_nxt;
            pend       <= pend_nxt;
        end
    end

    // Sticky overrun flag; a new overrun wins over clear_err.
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst)          overrun_err <= 1'b0;
        else if (ovr_set)   overrun_err <= 1'b1;
        else if (clear_err) overrun_err <= 1'b0;
    end

endmodule

// File: doc/column_scanner.md
COLUMN_SCANNER -- requirements
Module: column_scanner

Interface
REQ-001 SHALL have parameter N_COLS, default 8: number of LED columns driven; legal range 2..32.
REQ-002 SHALL have parameter DISP_CYCLES, default 330: clk_33 cycles one column stays on; legal range >= 1.
REQ-003 SHALL have parameter GAP_CYCLES, default 33: anti-ghosting blank cycles after each column; 0 allowed.
REQ-004 SHALL have parameter SYNC_DELAY, default 330: cycles from frame_sync to first column eligibility; 0 allowed.
REQ-005 SHALL have parameter MAX_ON_CYCLES, default 330: overdrive limit for any column, used only with the watchdog; legal range >= 1.
REQ-006 SHALL have port clk_33, input, 1 bit: 33.33 MHz system clock.
REQ-007 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1 bit: scanner run enable.
REQ-009 SHALL have port frame_sync, input, 1 bit: single-cycle pulse restarting the scan at column 0.
REQ-010 SHALL have port column_ready, input, 1 bit: single-cycle pulse, driver data for the next column latched.
REQ-011 SHALL have port clear_err, input, 1 bit: clears sticky error flags.
REQ-012 SHALL have port mux_out, output, N_COLS bits: one-hot column enable, all zero when off.
REQ-013 SHALL have port column_idx, output, $clog2(N_COLS) bits: current column index.
REQ-014 SHALL have port column_done, output, 1 bit: single-cycle pulse on the last DISP cycle.
REQ-015 SHALL have port overrun_err, output, 1 bit: sticky, column_ready arrived while one was already pending.
REQ-016 SHALL have port overdrive_err, output, 1 bit: sticky, watchdog cut a column.

Function
REQ-017 SHALL implement states IDLE, SYNC_WAIT, WAIT_READY, DISP and GAP, with a single cycle counter wide enough for max(DISP_CYCLES, GAP_CYCLES, SYNC_DELAY).
REQ-018 SHALL leave IDLE only on frame_sync while enable=1, going to SYNC_WAIT with column_idx=0 and the counter cleared.
REQ-019 SHALL hold SYNC_WAIT for exactly SYNC_DELAY cycles, or 0 cycles when SYNC_DELAY=0, then enter WAIT_READY.
REQ-020 SHALL set a 1-deep ready_pending flag whenever column_ready=1, in any state except IDLE.
REQ-021 SHALL set overrun_err on a column_ready that arrives while ready_pending is already set; ready_pending stays set.
REQ-022 In WAIT_READY, SHALL move to DISP on the next edge and clear ready_pending when ready_pending or column_ready is 1; otherwise it SHALL wait indefinitely.
REQ-023 SHALL decode mux_out from registered state as (1 << column_idx) iff state==DISP, else all zero, and SHALL never assert more than one bit.
REQ-024 SHALL stay in DISP exactly DISP_CYCLES cycles, pulse column_done on the last one, then enter GAP.
REQ-025 SHALL stay in GAP exactly GAP_CYCLES cycles with mux_out=0, then increment column_idx (N_COLS-1 wraps to 0) and enter WAIT_READY.
REQ-026 When GAP_CYCLES=0, SHALL increment column_idx and go from DISP directly to WAIT_READY.
REQ-027 SHALL give frame_sync with enable=1 priority over every other event in any state: go to SYNC_WAIT, idx=0, clear ready_pending, and set mux_out=0 from the next cycle.
REQ-028 On enable=0, SHALL go to IDLE on the next edge, clear ready_pending, and hold mux_out=0; sticky flags are kept.
REQ-029 SHALL clear both sticky flags on clear_err=1; a set condition in the same cycle wins.

Reset
REQ-030 On nrst=0, SHALL asynchronously set state=IDLE, counter=0, column_idx=0, ready_pending=0, overrun_err=0, overdrive_err=0, column_done=0 and mux_out=0.
REQ-031 SHALL force mux_out to zero while nrst=0, including reset asserted mid-DISP.

Configuration
REQ-032 With macro COLUMN_SCANNER_WATCHDOG_EN defined, an independent counter SHALL count consecutive cycles with mux_out nonzero.
REQ-033 When that counter reaches MAX_ON_CYCLES, SHALL force DISP to end, entering GAP (column_done still pulses), and set overdrive_err.
REQ-034 Without COLUMN_SCANNER_WATCHDOG_EN, SHALL have no watchdog logic, tie overdrive_err to 0, and ignore MAX_ON_CYCLES.

Verification
REQ-035 Bench SHALL cover: N_COLS=8, DISP=10, GAP=2, SYNC=5; frame_sync, then column_ready every 20 cycles -> columns 0..7 each on exactly 10 cycles, 2-cycle gaps, idx wraps 7->0.
REQ-036 Bench SHALL cover: column_ready issued during GAP -> pending honoured, DISP starts the cycle after GAP ends; a second pulse in that GAP -> overrun_err=1 until clear_err.
REQ-037 Bench SHALL cover: frame_sync at DISP cycle 4 of column 3 -> mux_out=0 next cycle, SYNC_WAIT 5 cycles, resume at column 0.
REQ-038 Bench SHALL cover: GAP=0, SYNC=0, N_COLS=4 -> no blank cycles between columns beyond the WAIT_READY handshake; idx wraps 3->0.
REQ-039 Bench SHALL cover: watchdog enabled, DISP=400, MAX_ON=330 -> each column cut at 330 cycles, overdrive_err=1; with the macro undefined, full 400 cycles and overdrive_err=0.
REQ-040 Bench SHALL cover: nrst low mid-DISP, and enable low mid-DISP -> mux_out=0 immediately on nrst and within one cycle on enable; a one-hot assertion on mux_out is checked throughout all scenarios.
